serial_ripple_sub: RTL and testbench

//   Bit-serial ripple-borrow subtractor: res = a - b - bin, one bit per clock, LSB first.

---
 rtl/serial_ripple_sub.sv | 113 +++++++++++
 tb/tb_serial_ripple_sub.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/serial_ripple_sub.sv
// Bit-serial ripple-borrow subtractor: res = a - b - bin, one bit per clock, LSB first.
// Optional signed-overflow output is enabled by defining SUB_OVF_EN.
module serial_ripple_sub #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               bin,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] res
`ifdef SUB_OVF_EN
   ,output logic               ovf
`endif
);

    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             bin_q;
    logic [WIDTH-1:0] diff_q;
    logic [WIDTH-1:0] brw_q;
    logic [WIDTH-1:0] diff_nxt;
    logic [WIDTH-1:0] brw_nxt;
    logic [IW-1:0]    idx;
    logic             last;
    logic             br;
    logic             ai;
    logic             bi;

    assign last      = (idx == IW'(WIDTH-1));
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // One full-subtractor cell applied to bit idx; the borrow chain lives in brw_q.
    always_comb begin
        diff_nxt      = diff_q;
        brw_nxt       = brw_q;
        ai            = a_q[idx];
        bi            = b_q[idx];
        br            = (idx == '0) ? bin_q : brw_q[idx - IW'(1)];
        diff_nxt[idx] = ai ^ bi ^ br;
        brw_nxt[idx]  = (~ai & bi) | (~(ai ^ bi) & br);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            bin_q  <= 1'b0;
            diff_q <= '0;
            brw_q  <= '0;
            idx    <= '0;
            res    <= '0;
`ifdef SUB_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q    <= a;
                        b_q    <= b;
                        bin_q  <= bin;
                        diff_q <= '0;
                        brw_q  <= '0;
                        idx    <= '0;
                    end
                end
                RUN: begin
                    diff_q <= diff_nxt;
                    brw_q  <= brw_nxt;
                    idx    <= last ? '0 : idx + IW'(1);
                    // The result register only moves on the final bit, so no partial value is visible.
                    if (last) begin
                        res <= {brw_nxt[WIDTH-1], diff_nxt, brw_nxt[WIDTH-2:0]};
`ifdef SUB_OVF_EN
                        ovf <= brw_nxt[WIDTH-1] ^ brw_nxt[WIDTH-2];
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_ripple_sub.sv
// Directed and randomised self-checking bench for serial_ripple_sub (WIDTH=8).
// Build with SUB_OVF_EN defined to also check the overflow output.
module tb_serial_ripple_sub;

    localparam int WIDTH = 8;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    a;
    logic [WIDTH-1:0]    b;
    logic                bin;
    logic                out_valid;
    logic                out_ready;
    logic [2*WIDTH-1:0]  res;
`ifdef SUB_OVF_EN
    logic                ovf;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    int prev_acc = 0;
    int edges;

    serial_ripple_sub #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res)
`ifdef SUB_OVF_EN
       ,.ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference built from unsigned comparisons of the low i+1 bits rather than a bit cell.
    function automatic logic [15:0] model(input logic [7:0] ma, input logic [7:0] mb, input logic mbin);
        logic [7:0] d;
        logic [7:0] br;
        logic [8:0] mask;
        d = ma - mb - {7'b0, mbin};
        for (int i = 0; i < 8; i++) begin
            mask  = (9'd2 << i) - 9'd1;
            br[i] = (({1'b0, ma} & mask) < (({1'b0, mb} & mask) + {8'b0, mbin}));
        end
        return {br[7], d, br[6:0]};
    endfunction

    function automatic logic model_ovf(input logic [7:0] ma, input logic [7:0] mb, input logic mbin);
        int s;
        s = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
        return (s < -128) || (s > 127);
    endfunction

    task automatic applyStimulus(input logic [7:0] va, input logic [7:0] vb, input logic vbin,
                                 input logic keep_valid);
        checkOutput("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        a        = va;
        b        = vb;
        bin      = vbin;
        @(posedge clk); #1;
        prev_acc = acc_cyc;
        acc_cyc  = cyc;
        in_valid = keep_valid;
        a        = 8'($urandom);
        b        = 8'($urandom);
        bin      = 1'($urandom);
    endtask

    task automatic waitDone(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!out_valid && n < 40);
    endtask

    task automatic runTxn(input logic [7:0] va, input logic [7:0] vb, input logic vbin,
                          input logic [15:0] exp_res, input logic exp_ovf);
        applyStimulus(va, vb, vbin, 1'b0);
        waitDone(edges);
        checkOutput("latency", edges, WIDTH);
        checkOutput("res", {16'b0, res}, {16'b0, exp_res});
`ifdef SUB_OVF_EN
        checkOutput("ovf", {31'b0, ovf}, {31'b0, exp_ovf});
`else
        if (exp_ovf === 1'bx) $display("[TB] unexpected X in expected ovf");
`endif
        @(posedge clk); #1;
        checkOutput("out_valid_after_handshake", {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        out_ready = 1'b1;
        #12;
        checkOutput("reset_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("reset_res", {16'b0, res}, 32'd0);
`ifdef SUB_OVF_EN
        checkOutput("reset_ovf", {31'b0, ovf}, 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        runTxn(8'h05, 8'h03, 1'b0, 16'h0102, 1'b0);
        runTxn(8'h00, 8'h01, 1'b0, 16'hFFFF, 1'b0);
        runTxn(8'h80, 8'h01, 1'b0, 16'h3FFF, 1'b1);
        runTxn(8'h7F, 8'hFF, 1'b0, 16'hC000, 1'b1);

        // Consumer stall: result must be held while out_ready stays low.
        out_ready = 1'b0;
        applyStimulus(8'h33, 8'h11, 1'b0, 1'b0);
        waitDone(edges);
        checkOutput("stall_latency", edges, WIDTH);
        for (int k = 0; k < 5; k++) begin
            checkOutput("stall_out_valid", {31'b0, out_valid}, 32'd1);
            checkOutput("stall_res", {16'b0, res}, 32'h1100);
            checkOutput("stall_in_ready", {31'b0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("release_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("release_out_valid", {31'b0, out_valid}, 32'd0);

        // Asynchronous reset in the middle of RUN aborts the operation.
        applyStimulus(8'h55, 8'h22, 1'b0, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        checkOutput("abort_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("abort_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("abort_res", {16'b0, res}, 32'd0);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            checkOutput("abort_no_result", {31'b0, out_valid}, 32'd0);
        end
        runTxn(8'h0A, 8'h0A, 1'b1, 16'hFFFF, 1'b0);

        // Back-to-back random traffic with in_valid held high.
        acc_cyc = 0;
        for (int n = 0; n < 1000; n++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic       rbin;
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rbin = 1'($urandom);
            applyStimulus(ra, rb, rbin, 1'b1);
            if (n > 0)
                checkOutput("issue_interval", acc_cyc - prev_acc, WIDTH + 2);
            waitDone(edges);
            checkOutput("rand_latency", edges, WIDTH);
            checkOutput("rand_res", {16'b0, res}, {16'b0, model(ra, rb, rbin)});
`ifdef SUB_OVF_EN
            checkOutput("rand_ovf", {31'b0, ovf}, {31'b0, model_ovf(ra, rb, rbin)});
`else
            if (model_ovf(ra, rb, rbin) === 1'bx) $display("[TB] unexpected X in overflow model");
`endif
            @(posedge clk); #1;
        end
        in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
